// File: rtl/controlador_dma.sv
// controlador_dma: byte-serial DMA engine for an 8-bit data memory port.
// A start pulse in IDLE latches the operands. The engine then either copies
// len bytes from src to dst, or fills len bytes at dst with fill_val.
// Addresses wrap modulo 256.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   start, mode               request pulse; 0 = copy, 1 = fill
//   src, dst, len, fill_val   operands, latched with start
//   busy, done                transfer active / one-cycle completion pulse
//   mem_addr, mem_r, mem_w    memory address and strobes
//   mem_din, mem_dout         memory write data / read data (1-cycle latency)
//
// state | meaning
// IDLE  | waiting for start, memory port quiet
// RD    | copy only: present src+i with mem_r
// WR    | write dst+i (copy: pass read data through, fill: fill_val)
// FIN   | one-cycle done pulse, memory port quiet
module controlador_dma (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       mode,
    input  logic [7:0] src,
    input  logic [7:0] dst,
    input  logic [7:0] len,
    input  logic [7:0] fill_val,
    output logic       busy,
    output logic       done,
    output logic [7:0] mem_addr,
    output logic       mem_r,
    output logic       mem_w,
    output logic [7:0] mem_din,
    input  logic [7:0] mem_dout
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        FIN  = 2'd3
    } state_t;

    state_t     state;
    logic       mode_q;
    logic [7:0] src_q;
    logic [7:0] dst_q;
    logic [7:0] len_q;
    logic [7:0] fill_q;
    logic [7:0] idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            mode_q <= 1'b0;
            src_q  <= 8'd0;
            dst_q  <= 8'd0;
            len_q  <= 8'd0;
            fill_q <= 8'd0;
            idx    <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mode_q <= mode;
                        src_q  <= src;
                        dst_q  <= dst;
                        len_q  <= len;
                        fill_q <= fill_val;
                        idx    <= 8'd0;
                        if (len == 8'd0)
                            state <= FIN;
                        else if (mode)
                            state <= WR;
                        else
                            state <= RD;
                    end
                end
                RD: state <= WR;
                WR: begin
                    idx <= idx + 8'd1;
                    // idx never exceeds len-1, so idx+1 fits in 8 bits even for len=255
                    if ((idx + 8'd1) == len_q)
                        state <= FIN;
                    else if (mode_q)
                        state <= WR;
                    else
                        state <= RD;
                end
                FIN:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs decode the registered state. The write strobe is masked by rst
    // so that a reset landing on a write cycle aborts before that byte commits.
    always_comb begin
        busy     = 1'b0;
        done     = 1'b0;
        mem_addr = 8'd0;
        mem_r    = 1'b0;
        mem_w    = 1'b0;
        mem_din  = 8'd0;
        case (state)
            RD: begin
                busy     = 1'b1;
                mem_addr = src_q + idx;
                mem_r    = 1'b1;
            end
            WR: begin
                busy     = 1'b1;
                mem_addr = dst_q + idx;
                mem_w    = ~rst;
                // copy keeps mem_r high so the byte read in RD stays valid this cycle
                mem_r    = ~mode_q;
                mem_din  = mode_q ? fill_q : mem_dout;
            end
            FIN:     done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_controlador_dma.sv
module tb_controlador_dma;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       mode;
    logic [7:0] src;
    logic [7:0] dst;
    logic [7:0] len;
    logic [7:0] fill_val;
    logic       busy;
    logic       done;
    logic [7:0] mem_addr;
    logic       mem_r;
    logic       mem_w;
    logic [7:0] mem_din;
    logic [7:0] mem_dout;

    controlador_dma dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .mode     (mode),
        .src      (src),
        .dst      (dst),
        .len      (len),
        .fill_val (fill_val),
        .busy     (busy),
        .done     (done),
        .mem_addr (mem_addr),
        .mem_r    (mem_r),
        .mem_w    (mem_w),
        .mem_din  (mem_din),
        .mem_dout (mem_dout)
    );

    always #5 clk = ~clk;

    // Synchronous memory: write commits at the edge, read data one cycle later.
    logic [7:0] mem     [256];
    logic [7:0] ref_mem [256];

    always @(posedge clk) begin
        if (mem_w) mem[mem_addr] <= mem_din;
        if (mem_r) mem_dout <= mem[mem_addr];
    end

    int checks = 0;
    int errors = 0;

    // Activity monitor, sampled mid-cycle.
    int cyc = 0;
    int busy_cnt, done_cnt, done_cyc, rd_cnt, wr_cnt, idle_bad;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (busy) busy_cnt = busy_cnt + 1;
        if (done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
        if (mem_r) rd_cnt = rd_cnt + 1;
        if (mem_w) wr_cnt = wr_cnt + 1;
        if (!busy && (mem_r || mem_w || mem_addr != 8'd0 || mem_din != 8'd0))
            idle_bad = idle_bad + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_counts();
        busy_cnt = 0; done_cnt = 0; done_cyc = -1;
        rd_cnt = 0; wr_cnt = 0; idle_bad = 0;
    endtask

    task automatic init_mem();
        for (int a = 0; a < 256; a++) begin
            mem[a]     = 8'($urandom);
            ref_mem[a] = mem[a];
        end
    endtask

    task automatic preset(input logic [7:0] a, input logic [7:0] v);
        mem[a]     = v;
        ref_mem[a] = v;
    endtask

    task automatic check_mem(input string tag);
        int mism = 0;
        for (int a = 0; a < 256; a++)
            if (mem[a] !== ref_mem[a]) mism++;
        check({tag, "_mem"}, 32'(mism), 32'd0);
    endtask

    // Reference: forward byte-serial copy/fill applied to the model memory.
    task automatic model_xfer(input bit m, input logic [7:0] s, input logic [7:0] d,
                              input int n, input logic [7:0] f);
        for (int k = 0; k < n; k++) begin
            logic [7:0] da = d + 8'(k);
            logic [7:0] sa = s + 8'(k);
            ref_mem[da] = m ? f : ref_mem[sa];
        end
    endtask

    task automatic run_xfer(input string tag, input bit m, input logic [7:0] s,
                            input logic [7:0] d, input logic [7:0] l,
                            input logic [7:0] f, input bit junk);
        int exp_busy;
        int start_cyc;
        int waited;
        model_xfer(m, s, d, int'(l), f);
        exp_busy = (l == 0) ? 0 : (m ? int'(l) : 2 * int'(l));
        @(posedge clk); #1;
        clear_counts();
        mode = m; src = s; dst = d; len = l; fill_val = f; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        start_cyc = cyc;
        if (junk) begin
            @(posedge clk); #1;
            start = 1'b1;
            mode = 1'($urandom); src = 8'($urandom); dst = 8'($urandom);
            len = 8'($urandom_range(1, 255)); fill_val = 8'($urandom);
            @(posedge clk); #1;
            start = 1'b0;
        end
        waited = 0;
        while (done_cnt == 0 && waited < 1000) begin
            @(posedge clk); #1;
            waited++;
        end
        check({tag, "_timeout"}, 32'(done_cnt != 0), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        check({tag, "_busy"},     32'(busy_cnt), 32'(exp_busy));
        check({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
        check({tag, "_done_cyc"}, 32'(done_cyc), 32'(start_cyc + exp_busy + 1));
        check({tag, "_writes"},   32'(wr_cnt),   32'(l));
        check({tag, "_reads"},    32'(rd_cnt),   32'(m ? 0 : 2 * int'(l)));
        check({tag, "_quiet"},    32'(idle_bad), 32'd0);
        check_mem(tag);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; mode = 1'b0;
        src = 8'd0; dst = 8'd0; len = 8'd0; fill_val = 8'd0;
        init_mem();
        clear_counts();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_mem_port", {13'd0, mem_r, mem_w, mem_addr, mem_din}, 32'd0);

        // reset wins over start at the same edge
        @(posedge clk); #1;
        rst = 1'b1; start = 1'b1; mode = 1'b1; len = 8'd5;
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0;
        check("rst_prio_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        check("rst_prio_busy2", 32'(busy), 32'd0);
        check("rst_prio_done", 32'(done), 32'd0);

        // directed copy
        preset(8'h10, 8'h01); preset(8'h11, 8'h02);
        preset(8'h12, 8'h03); preset(8'h13, 8'h04);
        run_xfer("copy4", 1'b0, 8'h10, 8'h40, 8'd4, 8'h00, 1'b0);
        check("copy4_b3", 32'(mem[8'h43]), 32'h04);

        // fill with address wrap
        run_xfer("fill_wrap", 1'b1, 8'h00, 8'hFE, 8'd3, 8'hA5, 1'b0);
        check("fill_wrap_b00", 32'(mem[8'h00]), 32'hA5);

        // zero length
        run_xfer("len0", 1'b0, 8'h33, 8'h44, 8'd0, 8'h00, 1'b0);

        // overlapping forward copy
        preset(8'h20, 8'h11); preset(8'h21, 8'h22); preset(8'h22, 8'h33);
        run_xfer("overlap", 1'b0, 8'h20, 8'h21, 8'd2, 8'h00, 1'b0);
        check("overlap_b22", 32'(mem[8'h22]), 32'h11);

        // abort during the third write cycle of an 8-byte copy
        model_xfer(1'b0, 8'h60, 8'h80, 2, 8'h00);
        @(posedge clk); #1;
        clear_counts();
        mode = 1'b0; src = 8'h60; dst = 8'h80; len = 8'd8; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("abort_in_wr", 32'(mem_w), 32'd1);
        rst = 1'b1;
        #1;
        check("abort_wr_masked", 32'(mem_w), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_mem_w", 32'(mem_w), 32'd0);
        repeat (4) @(posedge clk);
        #1;
        check("abort_no_done", 32'(done_cnt), 32'd0);
        check("abort_writes", 32'(wr_cnt), 32'd2);
        check_mem("abort");
        run_xfer("after_abort", 1'b0, 8'h05, 8'h90, 8'd3, 8'h00, 1'b0);

        // start while busy is ignored
        run_xfer("ign_copy", 1'b0, 8'hA0, 8'hB8, 8'd6, 8'h00, 1'b1);
        run_xfer("ign_fill", 1'b1, 8'h00, 8'hC0, 8'd5, 8'h5A, 1'b1);

        // maximum length
        run_xfer("fill255", 1'b1, 8'h00, 8'h81, 8'd255, 8'h3C, 1'b0);
        init_mem();
        run_xfer("copy255", 1'b0, 8'h17, 8'h9B, 8'd255, 8'h00, 1'b1);

        // randomized transfers
        for (int t = 0; t < 8; t++) begin
            bit         m;
            logic [7:0] l;
            m = 1'($urandom);
            l = 8'($urandom_range(1, 40));
            run_xfer($sformatf("rand%0d", t), m, 8'($urandom), 8'($urandom), l,
                     8'($urandom), (m ? (l >= 3) : 1'b1));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/controlador_dma.md
CONTROLADOR_DMA -- requirements
Module: controlador_dma

Interface
REQ-001 The block SHALL have no parameters; all address, data and length widths are fixed at 8 bits.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 start  input  1  request pulse; sampled only in IDLE.
REQ-005 mode  input  1  0 = copy src->dst, 1 = fill dst with fill_val; sampled with start.
REQ-006 src  input  8  copy source base address; sampled with start.
REQ-007 dst  input  8  destination base address; sampled with start.
REQ-008 len  input  8  byte count; 0 = no transfer; sampled with start.
REQ-009 fill_val  input  8  fill byte; sampled with start.
REQ-010 busy  output  1  high while a transfer occupies the memory port.
REQ-011 done  output  1  one-cycle completion pulse.
REQ-012 mem_addr  output  8  data-memory address.
REQ-013 mem_r  output  1  data-memory read enable.
REQ-014 mem_w  output  1  data-memory write enable.
REQ-015 mem_din  output  8  data-memory write data.
REQ-016 mem_dout  input  8  data-memory read data, valid one cycle after the address is presented with mem_r high; mem_r must remain high during that cycle.

Function
REQ-017 The block SHALL implement four states: IDLE, RD, WR, FIN.
REQ-018 In IDLE with start=1, the block SHALL latch mode, src, dst, len and fill_val, and clear the byte index i.
- len=0 -> FIN.
- mode=0 -> RD.
- mode=1 -> WR.
REQ-019 In RD, the block SHALL drive mem_addr=src+i, mem_r=1, mem_w=0, and then go to WR.
REQ-020 In WR, the block SHALL drive mem_addr=dst+i and mem_w=1.
- Copy: mem_r=1 and mem_din=mem_dout (combinational pass-through of the byte read in RD).
- Fill: mem_r=0 and mem_din=fill_val.
REQ-021 On leaving WR, the block SHALL increment i.
- If i+1 equals the latched len: next state FIN.
- Otherwise: copy -> RD, fill -> WR.
REQ-022 In FIN, the block SHALL drive done=1 and busy=0, with all memory outputs 0; next state IDLE.
REQ-023 busy SHALL be 1 exactly in RD and WR.
- Copy of N bytes: busy for 2N cycles.
- Fill of N bytes: busy for N cycles.
- done follows one cycle later in both cases.
REQ-024 In IDLE and FIN, the block SHALL drive mem_addr=0, mem_r=0, mem_w=0, mem_din=0.
REQ-025 Address arithmetic SHALL be modulo 256: src+i and dst+i wrap from 8'hFF to 8'h00 without error.
REQ-026 len=255 SHALL transfer 255 bytes; the index SHALL never overflow past len.
REQ-027 Overlapping copy SHALL be strictly forward and byte-serial.
- Each write commits before the next read issues.
- Result for dst>src overlap is defined as the byte-by-byte forward propagation.
REQ-028 start while busy or in FIN SHALL be ignored; input changes after acceptance SHALL not affect the active transfer.

Reset
REQ-029 With rst=1 at a rising edge, the block SHALL enter IDLE and clear i and all latched operands; from the next cycle busy=0, done=0 and all memory outputs are 0.
REQ-030 rst SHALL take priority over start at the same edge.
REQ-031 Reset mid-transfer SHALL abort with no further mem_w cycles; bytes already written are retained, and no done pulse is generated.

Verification
REQ-032 Copy: memory 10..13 = 01,02,03,04; start, mode=0, src=10, dst=40, len=4 -> busy 8 cycles; bytes 40..43 = 01,02,03,04; single done pulse one cycle after busy falls.
REQ-033 Fill wrap: mode=1, dst=FE, len=3, fill_val=A5 -> writes at FE, FF, 00 only; busy 3 cycles; done 1 cycle.
REQ-034 len=0: start, len=0 -> no mem_r/mem_w activity; busy stays 0; done one cycle after start edge.
REQ-035 Overlap: memory 20..22 = 11,22,33; copy src=20, dst=21, len=2 -> 21=11, 22=11.
REQ-036 Abort: copy len=8, assert rst during 3rd WR cycle -> exactly 2 bytes written; next cycle busy=0, mem_w=0; no done pulse; a later start runs normally.
REQ-037 Ignored start: pulse start with new operands while busy -> active transfer unchanged; no second transfer after done.
